// File: rtl/segment_swapchain.sv
// Active read-segment selector: swaps between two buffer segments on an immediate, index-wrap,
// system-time or GPIO trigger, and counts loop repetitions of the active segment.
module segment_swapchain #(
    parameter int unsigned IDX_W  = 15,
    parameter int unsigned TIME_W = 56
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              update,
    input  logic              req_rd_segment,
    input  logic [7:0]        transition_mode,
    input  logic [63:0]       transition_value,
    input  logic [15:0]       rep,
    input  logic [TIME_W-1:0] sys_time,
    input  logic [3:0]        gpio_in,
    input  logic [IDX_W-1:0]  idx,
    input  logic [IDX_W-1:0]  cycle,
    output logic              segment,
    output logic              stop,
    output logic              swap,
    output logic              busy
);

    localparam logic [7:0]  ModeSyncIdx   = 8'h00;
    localparam logic [7:0]  ModeSysTime   = 8'h01;
    localparam logic [7:0]  ModeGpio      = 8'h02;
    localparam logic [7:0]  ModeExt       = 8'h03;
    localparam logic [7:0]  ModeImmediate = 8'hFF;
    localparam logic [15:0] RepInfinite   = 16'hFFFF;

    typedef enum logic [2:0] {
        StRun,
        StStopped,
        StWaitIdx,
        StWaitTime,
        StWaitGpio,
        StExtRun
    } state_e;

    state_e              state_q, state_d;
    logic                segment_q, segment_d;
    logic                stop_q, stop_d;
    logic                swap_q, swap_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         rep_q, rep_d;
    logic                req_q, req_d;
    logic [TIME_W-1:0]   target_q, target_d;
    logic [1:0]          sel_q, sel_d;
    logic [IDX_W-1:0]    idx_prev_q;
    logic [3:0]          gpio_prev_q;

    logic mode_valid;
    logic accepted;
    logic wrap;
    logic gpio_rise;
    logic unused_value;

    assign mode_valid = (transition_mode == ModeSyncIdx) || (transition_mode == ModeSysTime) ||
                        (transition_mode == ModeGpio) || (transition_mode == ModeExt) ||
                        (transition_mode == ModeImmediate);
    assign accepted   = update && mode_valid;
    assign wrap       = (idx_prev_q == cycle) && (idx == '0);
    assign gpio_rise  = gpio_in[sel_q] && !gpio_prev_q[sel_q];
    assign unused_value = ^transition_value;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StRun;
            segment_q   <= 1'b0;
            stop_q      <= 1'b0;
            swap_q      <= 1'b0;
            cnt_q       <= '0;
            rep_q       <= RepInfinite;
            req_q       <= 1'b0;
            target_q    <= '0;
            sel_q       <= '0;
            idx_prev_q  <= '0;
            gpio_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            segment_q   <= segment_d;
            stop_q      <= stop_d;
            swap_q      <= swap_d;
            cnt_q       <= cnt_d;
            rep_q       <= rep_d;
            req_q       <= req_d;
            target_q    <= target_d;
            sel_q       <= sel_d;
            idx_prev_q  <= idx;
            gpio_prev_q <= gpio_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        segment_d = segment_q;
        stop_d    = stop_q;
        swap_d    = 1'b0;
        cnt_d     = cnt_q;
        rep_d     = rep_q;
        req_d     = req_q;
        target_d  = target_q;
        sel_d     = sel_q;

        // A valid UPDATE overrides any trigger, wrap or stop seen in the same cycle.
        if (accepted) begin
            req_d    = req_rd_segment;
            rep_d    = rep;
            target_d = transition_value[TIME_W-1:0];
            sel_d    = transition_value[1:0];
            case (transition_mode)
                ModeSyncIdx: state_d = StWaitIdx;
                ModeSysTime: state_d = StWaitTime;
                ModeGpio:    state_d = StWaitGpio;
                default: begin
                    state_d   = (transition_mode == ModeExt) ? StExtRun : StRun;
                    segment_d = req_rd_segment;
                    cnt_d     = '0;
                    stop_d    = 1'b0;
                    swap_d    = 1'b1;
                end
            endcase
        end else begin
            unique case (state_q)
                StRun: begin
                    if (wrap && (rep_q != RepInfinite)) begin
                        cnt_d = cnt_q + 16'd1;
                        if (cnt_q == rep_q) begin
                            state_d = StStopped;
                            stop_d  = 1'b1;
                        end
                    end
                end
                StStopped: ;
                StWaitIdx, StWaitTime, StWaitGpio: begin
                    if ((state_q == StWaitIdx && wrap) ||
                        (state_q == StWaitTime && sys_time >= target_q) ||
                        (state_q == StWaitGpio && gpio_rise)) begin
                        state_d   = StRun;
                        segment_d = req_q;
                        cnt_d     = '0;
                        stop_d    = 1'b0;
                        swap_d    = 1'b1;
                    end
                end
                StExtRun: begin
                    if (wrap) begin
                        segment_d = ~segment_q;
                        swap_d    = 1'b1;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        segment = segment_q;
        stop    = stop_q;
        swap    = swap_q;
        busy    = (state_q == StWaitIdx) || (state_q == StWaitTime) || (state_q == StWaitGpio);
    end

endmodule

// File: tb/tb_segment_swapchain.sv
// Randomised bench for segment_swapchain: an event-level reference model predicts
// segment/stop/swap/busy after each clock edge.
module tb_segment_swapchain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        update = 1'b0;
    logic        req_rd_segment = 1'b0;
    logic [7:0]  transition_mode = 8'h00;
    logic [63:0] transition_value = '0;
    logic [15:0] rep = 16'hFFFF;
    logic [55:0] sys_time = 56'd990;
    logic [3:0]  gpio_in = '0;
    logic [14:0] idx = '0;
    logic [14:0] cyc = 15'd3;
    logic        segment, stop, swap, busy;

    int total = 0;
    int bad = 0;

    // Reference model state
    bit          m_seg, m_stop, m_swap, m_ext, m_stopped, m_req;
    int          pend;      // 0 none, 1 index wrap, 2 system time, 3 gpio edge
    longint unsigned m_target;
    int          m_pin;
    int          m_rep;
    int          loops;
    int          prev_idx;
    logic [3:0]  prev_gpio;

    segment_swapchain dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .update           (update),
        .req_rd_segment   (req_rd_segment),
        .transition_mode  (transition_mode),
        .transition_value (transition_value),
        .rep              (rep),
        .sys_time         (sys_time),
        .gpio_in          (gpio_in),
        .idx              (idx),
        .cycle            (cyc),
        .segment          (segment),
        .stop             (stop),
        .swap             (swap),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit mode_ok(input logic [7:0] m);
        return (m <= 8'h03) || (m == 8'hFF);
    endfunction

    task automatic model_swap_to(input bit s);
        m_seg  = s;
        m_swap = 1'b1;
        m_stop = 1'b0;
        loops  = 0;
    endtask

    // Predicts the effect of the coming rising edge from the inputs currently applied.
    task automatic model_edge();
        bit wrap;
        bit rise;
        wrap = (prev_idx == int'(cyc)) && (idx == 0);
        rise = gpio_in[m_pin] && !prev_gpio[m_pin];
        m_swap = 1'b0;
        if (!rst_n) begin
            m_seg = 0; m_stop = 0; m_ext = 0; m_stopped = 0; m_req = 0;
            pend = 0; m_target = 0; m_pin = 0; m_rep = 16'hFFFF; loops = 0;
            prev_idx = 0; prev_gpio = '0;
            return;
        end
        if (update && mode_ok(transition_mode)) begin
            m_req = req_rd_segment;
            m_rep = rep;
            m_target = transition_value[55:0];
            m_pin = transition_value[1:0];
            m_ext = 0; m_stopped = 0; pend = 0;
            case (transition_mode)
                8'h00: pend = 1;
                8'h01: pend = 2;
                8'h02: pend = 3;
                8'h03: begin model_swap_to(m_req); m_ext = 1; end
                default: model_swap_to(m_req);
            endcase
        end else if ((pend == 1 && wrap) || (pend == 2 && sys_time >= m_target) ||
                     (pend == 3 && rise)) begin
            model_swap_to(m_req);
            pend = 0;
        end else if (m_ext && wrap) begin
            m_seg = !m_seg;
            m_swap = 1'b1;
        end else if (!m_ext && pend == 0 && !m_stopped && wrap && m_rep != 16'hFFFF) begin
            loops++;
            if (loops == m_rep + 1) begin
                m_stopped = 1;
                m_stop = 1;
            end
        end
        prev_idx = idx;
        prev_gpio = gpio_in;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_eq("segment", segment, m_seg);
        check_eq("stop", stop, m_stop);
        check_eq("swap", swap, m_swap);
        check_eq("busy", busy, pend != 0);
    endtask

    task automatic adv_idx();
        if (idx == cyc) idx = 0;
        else idx = idx + 1;
    endtask

    task automatic req(input logic [7:0] mode, input logic [63:0] val, input logic [15:0] r,
                       input bit s);
        update = 1'b1;
        transition_mode = mode;
        transition_value = val;
        rep = r;
        req_rd_segment = s;
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        step();

        // Immediate, REP=1 on a 4-entry segment: stops after the second wrap
        req(8'hFF, 64'd0, 16'd1, 1'b1);
        step();
        update = 1'b0;
        for (int i = 0; i < 14; i++) begin adv_idx(); step(); end
        // Undefined mode is ignored
        req(8'h42, 64'd0, 16'd0, 1'b0);
        step();
        update = 1'b0;

        // System time: second request replaces the first before its target
        sys_time = 56'd990;
        req(8'h01, 64'd1000, 16'hFFFF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (sys_time == 56'd995) req(8'h01, 64'd2000, 16'hFFFF, 1'b1);
            step();
            update = 1'b0;
            sys_time = sys_time + 1;
        end

        // GPIO pin 2 already high, then a genuine edge
        gpio_in = 4'b0100;
        req(8'h02, 64'hAB00_0000_0000_0002, 16'hFFFF, 1'b0);
        step();
        update = 1'b0;
        for (int i = 0; i < 8; i++) begin
            gpio_in[2] = (i >= 3);
            step();
        end

        // EXT toggling with reset mid-sequence
        idx = 0;
        req(8'h03, 64'd0, 16'd5, 1'b1);
        step();
        update = 1'b0;
        for (int i = 0; i < 14; i++) begin
            rst_n = (i != 10);
            adv_idx();
            step();
        end
        rst_n = 1'b1;

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            int r;
            rst_n = ($urandom_range(0, 299) != 0);
            update = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 5);
            transition_mode = (r < 4) ? 8'(r) : ((r == 4) ? 8'hFF : 8'h5A);
            req_rd_segment = $urandom_range(0, 1);
            case ($urandom_range(0, 4))
                0: rep = 16'd0;
                1: rep = 16'd1;
                2: rep = 16'd2;
                3: rep = 16'd3;
                default: rep = 16'hFFFF;
            endcase
            transition_value = {8'($urandom), 56'(sys_time + 56'($urandom_range(0, 40)) - 56'd10)};
            if (transition_mode == 8'h02) transition_value[1:0] = 2'($urandom_range(0, 3));
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) gpio_in[b] = ~gpio_in[b];
            if ($urandom_range(0, 3) != 0) adv_idx();
            if (idx == 0 && $urandom_range(0, 7) == 0) cyc = 15'($urandom_range(1, 5));
            sys_time = sys_time + 56'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
